// File: rtl/uart_rx_ctrl.sv
// UART receiver control FSM: paces each bit with an oversample edge counter,
// strobes the start/data/parity/stop checkers and qualifies the received frame.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [3:0]                bit_cnt,
    output logic                      dat_samp_en,
    output logic                      strt_chk_en,
    output logic                      deser_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      data_valid,
    output logic                      busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [PRESCALE_WIDTH-1:0] edge_nxt;
    logic [3:0]                bit_nxt;

    logic [PRESCALE_WIDTH-1:0] p_last;
    logic [PRESCALE_WIDTH-1:0] chk;
    logic [PRESCALE_WIDTH-1:0] stp_exit;
    logic                      at_last;
    logic                      at_chk;
    logic [PRESCALE_WIDTH-1:0] edge_inc;

    // Unsupported ratios fall back to x8 so the frame timing stays well defined.
    always_comb begin
        case (prescale)
            PRESCALE_WIDTH'(16): begin
                p_last   = PRESCALE_WIDTH'(15);
                chk      = PRESCALE_WIDTH'(10);
                stp_exit = PRESCALE_WIDTH'(11);
            end
            PRESCALE_WIDTH'(32): begin
                p_last   = PRESCALE_WIDTH'(31);
                chk      = PRESCALE_WIDTH'(18);
                stp_exit = PRESCALE_WIDTH'(19);
            end
            default: begin
                p_last   = PRESCALE_WIDTH'(7);
                chk      = PRESCALE_WIDTH'(6);
                stp_exit = PRESCALE_WIDTH'(7);
            end
        endcase
    end

    assign at_last  = (edge_cnt == p_last);
    assign at_chk   = (edge_cnt == chk);
    assign edge_inc = at_last ? '0 : edge_cnt + PRESCALE_WIDTH'(1);

    // NOTE: every output and next-state signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt   = state;
        edge_nxt    = '0;
        bit_nxt     = '0;
        dat_samp_en = 1'b0;
        busy        = 1'b0;
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        data_valid  = 1'b0;

        case (state)
            S_IDLE: begin
                if (!RX_IN) state_nxt = S_START;
            end

            S_START: begin
                dat_samp_en = 1'b1;
                busy        = 1'b1;
                strt_chk_en = at_chk;
                edge_nxt    = edge_inc;
                if (at_last) state_nxt = strt_glitch ? S_IDLE : S_DATA;
            end

            S_DATA: begin
                dat_samp_en = 1'b1;
                busy        = 1'b1;
                deser_en    = at_chk;
                edge_nxt    = edge_inc;
                bit_nxt     = bit_cnt;
                if (at_last) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = PAR_EN ? S_PARITY : S_STOP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + 4'd1;
                    end
                end
            end

            S_PARITY: begin
                dat_samp_en = 1'b1;
                busy        = 1'b1;
                par_chk_en  = at_chk;
                edge_nxt    = edge_inc;
                if (at_last) state_nxt = S_STOP;
            end

            // Leave one edge after the stop check so stp_err is already registered in DONE.
            S_STOP: begin
                dat_samp_en = 1'b1;
                busy        = 1'b1;
                stp_chk_en  = at_chk;
                edge_nxt    = edge_inc;
                if (edge_cnt == stp_exit) begin
                    state_nxt = S_DONE;
                    edge_nxt  = '0;
                end
            end

            S_DONE: begin
                data_valid = !stp_err && !(PAR_EN && par_err);
                state_nxt  = RX_IN ? S_IDLE : S_START;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: reset is synchronous and active-low; state updates use non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= S_IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            edge_cnt <= edge_nxt;
            bit_cnt  <= bit_nxt;
        end
    end

    strobes_exclusive : assert property (@(posedge CLK) disable iff (!RST)
        $onehot0({strt_chk_en, deser_en, par_chk_en, stp_chk_en}));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives frames through the control FSM and
// checks strobe positions, frame length and data_valid against hand-derived values.
module tb_uart_rx_ctrl;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-frame observations filled in by observe().
    int   n_strt, n_deser, n_par, n_stp, n_valid, n_overlap;
    int   n_bad_edge, n_bad_bit, n_bad_samp;
    int   strt_edge, par_edge, stp_edge, end_cyc, end_edge, first_edge;
    logic end_valid, first_busy, last_busy;

    uart_rx_ctrl #(
        .DATA_WIDTH    (8),
        .PRESCALE_WIDTH(6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .prescale   (prescale),
        .strt_glitch(strt_glitch),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en),
        .deser_en   (deser_en),
        .par_chk_en (par_chk_en),
        .stp_chk_en (stp_chk_en),
        .data_valid (data_valid),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Runs one frame, sampling on falling edges. Cycle 0 is the first START cycle.
    // low_cyc = cycles RX_IN is held low (0 = keep low, returning right at DONE).
    task automatic observe(input int chk, input int low_cyc, input bit started);
        n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0; n_valid = 0; n_overlap = 0;
        n_bad_edge = 0; n_bad_bit = 0; n_bad_samp = 0;
        strt_edge = -1; par_edge = -1; stp_edge = -1; end_cyc = -1; end_edge = -1;
        first_edge = -1; end_valid = 1'b0; first_busy = 1'b0; last_busy = 1'b1;
        if (!started) begin
            RX_IN = 1'b0;
            @(posedge CLK);
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                first_edge = int'(edge_cnt);
                first_busy = busy;
            end
            if ($countones({strt_chk_en, deser_en, par_chk_en, stp_chk_en}) > 1) n_overlap++;
            if (busy !== dat_samp_en) n_bad_samp++;
            if (strt_chk_en) begin n_strt++; strt_edge = int'(edge_cnt); end
            if (deser_en) begin
                if (int'(edge_cnt) != chk) n_bad_edge++;
                if (bit_cnt !== 4'(n_deser)) n_bad_bit++;
                n_deser++;
            end
            if (par_chk_en) begin n_par++; par_edge = int'(edge_cnt); end
            if (stp_chk_en) begin n_stp++; stp_edge = int'(edge_cnt); end
            if (data_valid) n_valid++;
            last_busy = busy;
            if (low_cyc > 0 && i == low_cyc - 1) RX_IN = 1'b1;
            if (end_cyc < 0 && !busy) begin
                end_cyc   = i;
                end_edge  = int'(edge_cnt);
                end_valid = data_valid;
                if (low_cyc == 0) break;
            end
            if (end_cyc >= 0 && i >= end_cyc + 3) break;
        end
    endtask

    task automatic test_reset;
        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_checks++; if ({busy, dat_samp_en, data_valid} !== 3'b000) begin n_fail++;
            $display("FAIL reset_status: got %b expected 000", {busy, dat_samp_en, data_valid}); end
        n_checks++; if ({strt_chk_en, deser_en, par_chk_en, stp_chk_en} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_strobes: got %b expected 0000", {strt_chk_en, deser_en, par_chk_en, stp_chk_en}); end
        n_checks++; if (edge_cnt !== 6'd0) begin n_fail++;
            $display("FAIL reset_edge_cnt: got %0d expected 0", edge_cnt); end
        n_checks++; if (bit_cnt !== 4'd0) begin n_fail++;
            $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
        RST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    // P=8, no parity: 8 START + 64 DATA + 8 STOP cycles, DONE at cycle 80.
    task automatic test_basic_p8;
        prescale = 6'd8; PAR_EN = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        observe(6, 1, 1'b0);
        n_checks++; if (end_cyc !== 80) begin n_fail++; $display("FAIL p8_done_cycle: got %0d expected 80", end_cyc); end
        n_checks++; if (n_deser !== 8) begin n_fail++; $display("FAIL p8_deser_count: got %0d expected 8", n_deser); end
        n_checks++; if (n_bad_edge !== 0) begin n_fail++; $display("FAIL p8_deser_edge: got %0d off-edge pulses expected 0", n_bad_edge); end
        n_checks++; if (n_bad_bit !== 0) begin n_fail++; $display("FAIL p8_deser_bit_cnt: got %0d misordered expected 0", n_bad_bit); end
        n_checks++; if (n_strt !== 1 || strt_edge !== 6) begin n_fail++; $display("FAIL p8_strt_chk: got %0d pulses at edge %0d expected 1 at 6", n_strt, strt_edge); end
        n_checks++; if (n_stp !== 1 || stp_edge !== 6) begin n_fail++; $display("FAIL p8_stp_chk: got %0d pulses at edge %0d expected 1 at 6", n_stp, stp_edge); end
        n_checks++; if (n_par !== 0) begin n_fail++; $display("FAIL p8_no_par_chk: got %0d expected 0", n_par); end
        n_checks++; if (end_valid !== 1'b1 || n_valid !== 1) begin n_fail++; $display("FAIL p8_data_valid: got %b/%0d cycles expected 1/1", end_valid, n_valid); end
        n_checks++; if (end_edge !== 0) begin n_fail++; $display("FAIL p8_done_edge: got %0d expected 0", end_edge); end
        n_checks++; if (n_overlap !== 0 || n_bad_samp !== 0) begin n_fail++; $display("FAIL p8_strobe_hygiene: got %0d/%0d expected 0/0", n_overlap, n_bad_samp); end
    endtask

    // P=16 with parity: 16 + 128 + 16 + 12 (STOP exits at edge 11) -> DONE at 172.
    task automatic test_parity_err_p16;
        prescale = 6'd16; PAR_EN = 1'b1; par_err = 1'b1; stp_err = 1'b0;
        observe(10, 1, 1'b0);
        n_checks++; if (end_cyc !== 172) begin n_fail++; $display("FAIL p16_done_cycle: got %0d expected 172", end_cyc); end
        n_checks++; if (n_par !== 1 || par_edge !== 10) begin n_fail++; $display("FAIL p16_par_chk: got %0d pulses at edge %0d expected 1 at 10", n_par, par_edge); end
        n_checks++; if (n_deser !== 8 || n_bad_edge !== 0) begin n_fail++; $display("FAIL p16_deser: got %0d pulses, %0d off-edge expected 8, 0", n_deser, n_bad_edge); end
        n_checks++; if (stp_edge !== 10) begin n_fail++; $display("FAIL p16_stp_edge: got %0d expected 10", stp_edge); end
        n_checks++; if (n_valid !== 0) begin n_fail++; $display("FAIL p16_par_err_valid: got %0d expected 0", n_valid); end
        par_err = 1'b0;
    endtask

    // P=32 with clean parity: 32 + 256 + 32 + 20 -> DONE at 340.
    task automatic test_parity_ok_p32;
        prescale = 6'd32; PAR_EN = 1'b1; par_err = 1'b0; stp_err = 1'b0;
        observe(18, 1, 1'b0);
        n_checks++; if (end_cyc !== 340) begin n_fail++; $display("FAIL p32_done_cycle: got %0d expected 340", end_cyc); end
        n_checks++; if (par_edge !== 18 || n_bad_edge !== 0) begin n_fail++; $display("FAIL p32_chk_edge: got par %0d, %0d off-edge expected 18, 0", par_edge, n_bad_edge); end
        n_checks++; if (n_valid !== 1) begin n_fail++; $display("FAIL p32_data_valid: got %0d expected 1", n_valid); end
    endtask

    task automatic test_par_err_ignored;
        prescale = 6'd8; PAR_EN = 1'b0; par_err = 1'b1; stp_err = 1'b0;
        observe(6, 1, 1'b0);
        n_checks++; if (n_valid !== 1 || n_par !== 0) begin n_fail++; $display("FAIL par_ignored: got valid %0d par %0d expected 1, 0", n_valid, n_par); end
        par_err = 1'b0;
    endtask

    task automatic test_glitch;
        prescale = 6'd8; PAR_EN = 1'b0; strt_glitch = 1'b1;
        observe(6, 2, 1'b0);
        n_checks++; if (end_cyc !== 8) begin n_fail++; $display("FAIL glitch_idle_cycle: got %0d expected 8", end_cyc); end
        n_checks++; if (n_strt !== 1 || strt_edge !== 6) begin n_fail++; $display("FAIL glitch_strt_chk: got %0d at edge %0d expected 1 at 6", n_strt, strt_edge); end
        n_checks++; if (n_deser !== 0 || n_stp !== 0 || n_valid !== 0) begin n_fail++; $display("FAIL glitch_quiet: got deser %0d stp %0d valid %0d expected 0", n_deser, n_stp, n_valid); end
        strt_glitch = 1'b0;
    endtask

    task automatic test_stop_err;
        prescale = 6'd8; PAR_EN = 1'b0; stp_err = 1'b1;
        observe(6, 1, 1'b0);
        n_checks++; if (end_cyc !== 80) begin n_fail++; $display("FAIL stp_err_done_cycle: got %0d expected 80", end_cyc); end
        n_checks++; if (n_valid !== 0) begin n_fail++; $display("FAIL stp_err_valid: got %0d expected 0", n_valid); end
        n_checks++; if (last_busy !== 1'b0) begin n_fail++; $display("FAIL stp_err_idle: got busy %b expected 0", last_busy); end
        stp_err = 1'b0;
    endtask

    task automatic test_back_to_back;
        prescale = 6'd8; PAR_EN = 1'b0;
        observe(6, 0, 1'b0);
        n_checks++; if (end_cyc !== 80 || end_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got done %0d valid %b expected 80, 1", end_cyc, end_valid); end
        observe(6, 1, 1'b1);
        n_checks++; if (first_busy !== 1'b1 || first_edge !== 0) begin n_fail++; $display("FAIL b2b_restart: got busy %b edge %0d expected 1, 0", first_busy, first_edge); end
        n_checks++; if (end_cyc !== 80 || n_valid !== 1) begin n_fail++; $display("FAIL b2b_second: got done %0d valid %0d expected 80, 1", end_cyc, n_valid); end
    endtask

    // Data bit 3, edge 4 is cycle 8 + 3*8 + 4 = 36 of the frame.
    task automatic test_reset_mid;
        int activity;
        prescale = 6'd8; PAR_EN = 1'b0;
        RX_IN = 1'b0;
        @(posedge CLK);
        for (int i = 0; i <= 36; i++) begin
            @(negedge CLK);
            if (i == 0) RX_IN = 1'b1;
        end
        n_checks++; if (bit_cnt !== 4'd3 || edge_cnt !== 6'd4) begin n_fail++; $display("FAIL mid_position: got bit %0d edge %0d expected 3, 4", bit_cnt, edge_cnt); end
        RST = 1'b0;
        @(negedge CLK);
        n_checks++; if ({busy, dat_samp_en, data_valid, strt_chk_en, deser_en, par_chk_en, stp_chk_en, edge_cnt, bit_cnt} !== 17'd0) begin n_fail++;
            $display("FAIL mid_reset_outputs: got busy %b edge %0d bit %0d expected all 0", busy, edge_cnt, bit_cnt); end
        RST = 1'b1;
        activity = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (busy || data_valid || strt_chk_en || deser_en || par_chk_en || stp_chk_en) activity++;
        end
        n_checks++; if (activity !== 0) begin n_fail++; $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", activity); end
    endtask

    task automatic test_illegal_prescale;
        prescale = 6'd12; PAR_EN = 1'b0;
        observe(6, 1, 1'b0);
        n_checks++; if (end_cyc !== 80) begin n_fail++; $display("FAIL p12_done_cycle: got %0d expected 80", end_cyc); end
        n_checks++; if (n_deser !== 8 || n_bad_edge !== 0 || stp_edge !== 6) begin n_fail++;
            $display("FAIL p12_timing: got deser %0d off-edge %0d stp edge %0d expected 8, 0, 6", n_deser, n_bad_edge, stp_edge); end
        n_checks++; if (n_valid !== 1) begin n_fail++; $display("FAIL p12_data_valid: got %0d expected 1", n_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_p8();
        test_parity_err_p16();
        test_parity_ok_p32();
        test_par_err_ignored();
        test_glitch();
        test_stop_err();
        test_back_to_back();
        test_reset_mid();
        test_illegal_prescale();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Control FSM of the UART receiver; sits directly upstream of the stop-bit checker and the other RX check stages.
- Owns the per-bit edge counter and the data-bit counter.
- Issues one-cycle enables to the start, data, parity and stop checkers and to the deserializer.
- Collects their registered error flags and raises data_valid for clean frames.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of the prescale input and of the edge_cnt output.

Ports:
- CLK  in  1  oversampling clock.
- RST  in  1  synchronous active-low reset, sampled on the CLK rising edge.
- RX_IN  in  1  serial line, idle high.
- PAR_EN  in  1  1 = frame contains a parity bit.
- prescale  in  PRESCALE_WIDTH  oversampling ratio P; 8, 16 or 32. Any other value is treated as 8.
- strt_glitch  in  1  registered start-check result, 1 = false start.
- par_err  in  1  registered parity-check result.
- stp_err  in  1  registered stop-check result.
- edge_cnt  out  PRESCALE_WIDTH  oversample index within the current bit, 0..P-1.
- bit_cnt  out  4  data-bit index, 0..DATA_WIDTH-1.
- dat_samp_en  out  1  sampler enable.
- strt_chk_en  out  1  start-check strobe.
- deser_en  out  1  deserializer shift strobe.
- par_chk_en  out  1  parity-check strobe.
- stp_chk_en  out  1  stop-check strobe.
- data_valid  out  1  frame accepted.
- busy  out  1  frame in progress.

Behaviour:
- Reset:
  - RST low at a rising edge forces state IDLE and clears edge_cnt and bit_cnt.
  - All outputs are 0 from the following cycle.
  - Reset mid-frame aborts the frame; no data_valid is produced.
- CHK = P/2+2, the cycle at which the sampler's majority result is stable. Strobes fire only when edge_cnt == CHK.
- edge_cnt:
  - Increments every cycle in START, DATA, PARITY and STOP.
  - Wraps P-1 -> 0 at each bit boundary.
  - Held at 0 in IDLE and DONE.
- dat_samp_en and busy are 1 in START, DATA, PARITY and STOP; 0 otherwise.
- IDLE:
  - RX_IN == 0 -> START on the next cycle with edge_cnt = 0.
- START:
  - strt_chk_en pulses at CHK.
  - At edge_cnt == P-1: if strt_glitch == 1 -> IDLE (frame dropped silently); otherwise -> DATA with bit_cnt = 0.
- DATA:
  - deser_en pulses at CHK.
  - At edge_cnt == P-1: if bit_cnt == DATA_WIDTH-1 -> PARITY when PAR_EN = 1, else STOP. Otherwise bit_cnt increments.
- PARITY:
  - par_chk_en pulses at CHK.
  - At edge_cnt == P-1 -> STOP.
- STOP:
  - stp_chk_en pulses at CHK.
  - At edge_cnt == CHK+1 (stp_err now registered) -> DONE. Leaving early frees margin for back-to-back frames.
- DONE (exactly one cycle):
  - data_valid = !stp_err && !(PAR_EN && par_err).
  - Next state is START if RX_IN == 0, else IDLE.
- Boundary rules:
  - A one-cycle low glitch in IDLE still enters START and is rejected via strt_glitch. No data strobes fire.
  - PAR_EN and prescale must be static during a frame. The FSM latches neither; a change mid-frame has unspecified results.
  - par_err is ignored when PAR_EN = 0.
  - Every strobe is high for at most one cycle per bit and never overlaps another strobe.

Test Plan:
- P=8, PAR_EN=0, byte 0xA5, stop=1, no errors:
  - 8 deser_en pulses, each at edge_cnt==6, bit_cnt 0..7.
  - One stp_chk_en pulse, no par_chk_en.
  - data_valid=1 for exactly 1 cycle; 16+... total frame 9 bits*8 + 8 cycles to DONE.
- P=16, PAR_EN=1, strobe stp_err=0, par_err=1 in PARITY:
  - par_chk_en pulses at edge_cnt==10.
  - DONE is reached and data_valid stays 0.
- P=8, RX_IN low 2 cycles then high, strt_glitch driven 1:
  - One strt_chk_en pulse, return to IDLE at edge 7.
  - No deser_en, busy falls, data_valid stays 0.
- P=8, PAR_EN=0, stp_err=1:
  - data_valid stays 0 in DONE; FSM returns to IDLE.
- Back-to-back frames, RX_IN=0 in the DONE cycle:
  - Direct DONE->START, edge_cnt restarts at 0.
  - Second frame yields its own data_valid.
- RST low at DATA bit 3, edge 4:
  - Next cycle all outputs are 0 and state is IDLE.
  - With RX_IN high afterward, no strobes fire.
- prescale=12 (illegal): timing is identical to P=8 (CHK=6).
